// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Imported by the arbiter and anything that inspects its state.
package mem_arb_pkg;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_MAX_WAIT = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_e;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_e;

   function automatic owner_e owner_of(arb_state_e s);
      return (s == BUSY_D) ? OWN_D : OWN_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and the MEM stage.
// Data has priority; a starve counter bounds how long fetch waits.
import mem_arb_pkg::*;

module mem_port_arbiter #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   arb_state_e       state;
   logic [CNT_W-1:0] starve;
   logic             starved;
   logic             idle;
   logic             unused_lsbs;

   // byte offset bits never reach the word-addressed memory
   assign unused_lsbs = ^{if_addr[1:0], d_addr[1:0]};

   assign idle    = (state == IDLE);
   assign starved = (starve == CNT_MAX);

   // data wins unless fetch has waited too long; an absent fetch
   // never blocks data. Reset masks grants so outputs clear at once.
   assign d_gnt  = rst & idle & d_req & (~starved | ~if_req);
   assign if_gnt = rst & idle & if_req & ~d_gnt;

   // transaction FSM: latch request on grant, finish on first ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (d_gnt) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
               end else if (if_gnt) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= '0;
                  mem_be    <= '1;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (owner_of(state) == OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= mem_rdata;
                  end else begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // count data grants that bypassed a waiting fetch, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve <= '0;
      end else if (if_gnt) begin
         starve <= '0;
      end else if (d_gnt && if_req && !starved) begin
         starve <= starve + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table
// plus hand sequences for starvation, slow ack and mid-flight reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dbe;
      logic        ack;
      logic [31:0] mrd;
      logic [159:0] exp;
   } vec_t;

   vec_t tbl[$];

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [159:0] pack(
      input logic ig, input logic dg, input logic irv,
      input logic drv, input logic mreq, input logic mwe,
      input logic [3:0] mbe, input logic [31:0] maddr,
      input logic [31:0] mwd, input logic [31:0] ird,
      input logic [31:0] drd);
      return {22'd0, ig, dg, irv, drv, mreq, mwe,
              mbe, maddr, mwd, ird, drd};
   endfunction

   function automatic logic [159:0] obs();
      return pack(if_gnt, d_gnt, if_rvalid, d_rvalid,
                  mem_req, mem_we, mem_be, mem_addr,
                  mem_wdata, if_rdata, d_rdata);
   endfunction

   task automatic check(input string name,
                        input logic [159:0] act,
                        input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(
      input string n, input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw, input logic [31:0] da,
      input logic [31:0] dwd, input logic [3:0] dbe,
      input logic ack, input logic [31:0] mrd,
      input logic [159:0] exp);
      vec_t v;
      v.name = n;
      v.ir = ir;   v.ia = ia;
      v.dr = dr;   v.dw = dw;
      v.da = da;   v.dwd = dwd;
      v.dbe = dbe; v.ack = ack;
      v.mrd = mrd; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic zero_inputs();
      if_req = 0; if_addr = '0;
      d_req = 0;  d_we = 0;
      d_addr = '0; d_wdata = '0;
      d_be = '0;  mem_ack = 0;
      mem_rdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] W0 = 32'h003100B3;
   localparam logic [31:0] WB = 32'hDEADBEEF;

   initial begin
      int n;
      int cyc;
      logic got [6];
      logic want [6];

      rst = 0;
      zero_inputs();

      // per-cycle vectors: inputs, then expected
      // (ig dg irv drv mreq mwe mbe maddr mwd ird drd)
      add("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(0,0,0,0,0,0,4'h0,0,0,0,0));
      add("f_gnt", 1, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(1,0,0,0,0,0,4'h0,0,0,0,0));
      add("f_busy", 0, 0, 0, 0, 0, 0, 0, 1, W0,
          pack(0,0,0,0,1,0,4'hF,0,0,0,0));
      add("f_rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(0,0,1,0,0,0,4'hF,0,0,W0,0));
      add("sim_dgnt", 1, 4, 1, 0, 4, 0, 4'hF, 0, 0,
          pack(0,1,0,0,0,0,4'hF,0,0,W0,0));
      add("sim_dbusy", 1, 4, 0, 0, 0, 0, 0, 1, WB,
          pack(0,0,0,0,1,0,4'hF,4,0,W0,0));
      add("sim_fgnt", 1, 4, 0, 0, 0, 0, 0, 0, 0,
          pack(1,0,0,1,0,0,4'hF,4,0,W0,WB));
      add("sim_fbusy", 0, 0, 0, 0, 0, 0, 0, 1, WB,
          pack(0,0,0,0,1,0,4'hF,4,0,W0,WB));
      add("sim_frvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(0,0,1,0,0,0,4'hF,4,0,WB,WB));
      add("wr_gnt", 0, 0, 1, 1, 7, 32'h1234, 4'h3, 0, 0,
          pack(0,1,0,0,0,0,4'hF,4,0,WB,WB));
      add("wr_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0,
          pack(0,0,0,0,1,1,4'h3,4,32'h1234,WB,WB));
      add("wr_done", 0, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(0,0,0,1,0,1,4'h3,4,32'h1234,WB,0));
      add("idle_ack", 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,
          pack(0,0,0,0,0,1,4'h3,4,32'h1234,WB,0));
      add("idle_ack_after", 0, 0, 0, 0, 0, 0, 0, 0, 0,
          pack(0,0,0,0,0,1,4'h3,4,32'h1234,WB,0));

      // reset state, with requests present to prove grants are masked
      #3;
      if_req = 1;
      d_req = 1;
      #1;
      check("reset_outs", obs(), '0);
      zero_inputs();
      @(posedge clk);
      step();
      rst = 1;

      foreach (tbl[i]) begin
         if_req = tbl[i].ir;   if_addr = tbl[i].ia;
         d_req = tbl[i].dr;    d_we = tbl[i].dw;
         d_addr = tbl[i].da;   d_wdata = tbl[i].dwd;
         d_be = tbl[i].dbe;    mem_ack = tbl[i].ack;
         mem_rdata = tbl[i].mrd;
         @(negedge clk);
         check(tbl[i].name, obs(), tbl[i].exp);
         step();
      end
      zero_inputs();

      // starvation: both held, memory always acking
      want = '{0, 0, 0, 0, 1, 0};
      if_req = 1; if_addr = 32'h8;
      d_req = 1;  d_addr = 32'hC; d_be = 4'hF;
      mem_ack = 1;
      n = 0;
      cyc = 0;
      while (n < 6 && cyc < 40) begin
         @(negedge clk);
         if (d_gnt || if_gnt) begin
            got[n] = if_gnt;
            n++;
         end
         cyc++;
         step();
      end
      if_req = 0;
      d_req = 0;
      step();
      mem_ack = 0;
      check("starve_count", 160'(n), 160'(6));
      for (int k = 0; k < 6; k++) begin
         if (k < n)
            check($sformatf("starve_gnt%0d", k),
                  160'(got[k]), 160'(want[k]));
      end

      // slow memory: ack after 5 extra cycles, fetch waiting
      zero_inputs();
      d_req = 1; d_addr = 32'h10; d_be = 4'hF;
      @(negedge clk);
      check("dly_gnt", {d_gnt, if_gnt}, 2'b10);
      step();
      d_req = 0;
      if_req = 1; if_addr = 32'h20;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) begin
            mem_ack = 1;
            mem_rdata = 32'hCAFE0001;
         end
         @(negedge clk);
         check($sformatf("dly_hold%0d", k),
               {if_gnt, d_gnt, mem_req, mem_we,
                mem_be, mem_addr, mem_wdata},
               {1'b0, 1'b0, 1'b1, 1'b0,
                4'hF, 32'h10, 32'h0});
         step();
      end
      mem_ack = 0;
      @(negedge clk);
      check("dly_rvalid", {d_rvalid, d_rdata, if_gnt},
            {1'b1, 32'hCAFE0001, 1'b1});
      step();
      if_req = 0;
      mem_ack = 1;
      mem_rdata = 32'h11;
      @(negedge clk);
      check("dly_fbusy", {mem_req, mem_addr, mem_we},
            {1'b1, 32'h20, 1'b0});
      step();
      mem_ack = 0;
      @(negedge clk);
      check("dly_frvalid", {if_rvalid, if_rdata},
            {1'b1, 32'h11});
      step();

      // reset while a data write is in flight
      zero_inputs();
      d_req = 1; d_we = 1; d_addr = 32'h40;
      d_wdata = 32'hAAAA; d_be = 4'hF;
      @(negedge clk);
      check("rst_gnt", 160'(d_gnt), 160'(1));
      step();
      d_req = 0; d_we = 0;
      if_req = 1; if_addr = 32'h44;
      @(negedge clk);
      check("rst_busy", {mem_req, mem_we}, 2'b11);
      #2;
      rst = 0;
      #1;
      check("rst_clear", obs(), '0);
      step();
      if_req = 0;
      mem_ack = 1;
      mem_rdata = 32'h99;
      rst = 1;
      @(negedge clk);
      check("rst_rel0", {d_rvalid, if_rvalid, mem_req, d_rdata},
            '0);
      step();
      mem_ack = 0;
      @(negedge clk);
      check("rst_rel1", {d_rvalid, if_rvalid, mem_req, d_rdata},
            '0);
      step();
      if_req = 1; if_addr = 32'h48;
      @(negedge clk);
      check("rst_next_gnt", {if_gnt, d_gnt}, 2'b10);
      step();
      if_req = 0;
      mem_ack = 1;
      mem_rdata = 32'h77;
      @(negedge clk);
      check("rst_next_busy", {mem_req, mem_addr, mem_be},
            {1'b1, 32'h48, 4'hF});
      step();
      mem_ack = 0;
      @(negedge clk);
      check("rst_next_rvalid", {if_rvalid, if_rdata},
            {1'b1, 32'h77});
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported unified memory between the pipeline's instruction-fetch (IF) requester and the MEM-stage data requester. Sits between the core's fetch and MEM stages and the memory. Each access runs as a request/grant/response transaction. Data accesses have priority, and a starvation guard bounds how long fetch can wait.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 4, number of consecutive data grants made while fetch waits before fetch is forced to win
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetched word
- d_req, d_we  in  1  data request / write; held with address, data and byte enables until d_gnt
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data accepted (1-cycle pulse)
- d_rvalid  out  1  read data valid, or write complete (1-cycle pulse)
- d_rdata  out  DATA_W  read data
- mem_req, mem_we  out  1  memory request / write
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are forced to 0
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables
- mem_ack  in  1  memory done; rdata is valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, no request: stay in IDLE.
- IDLE, with requests:
  - If d_req and the starve counter is below MAX_WAIT: assert d_gnt, latch the request, go to BUSY_D.
  - Otherwise, if if_req: assert if_gnt, latch the request, go to BUSY_I.
- Grants are combinational in IDLE only. A grant is never asserted in BUSY_I or BUSY_D.
- Fetch transactions always drive mem_we=0 and mem_be=all-ones.
- BUSY_x: mem_req and all latched mem_* outputs are held stable until mem_ack.
- On mem_ack:
  - Register mem_rdata into the owner's rdata.
  - Pulse the owner's rvalid in the next cycle.
  - Go to IDLE.
- Writes: d_rvalid pulses as the write-complete indication; d_rdata carries mem_rdata, which is don't-care.
- Starve counter (width clog2(MAX_WAIT+1)):
  - Increments when d_gnt is given while if_req is high.
  - Clears on if_gnt.
  - Saturates at MAX_WAIT.
- if_rdata and d_rdata hold their last value between pulses.

## Timing
- Reset value of every output is 0, including rdata registers; state resets to IDLE and the starve counter to 0.
- Minimum latency: gnt in cycle t, mem_req from t+1, mem_ack at t+1 at earliest, rvalid at t+2.
- Back-to-back: the FSM is in IDLE in the rvalid cycle, so a new grant may coincide with rvalid. Peak rate is one transaction per 2 cycles.
- Simultaneous if_req and d_req in IDLE: data wins unless the starve counter equals MAX_WAIT.
- mem_ack in IDLE is ignored, as is any mem_ack beyond the first per transaction.
- Requester deasserts req before gnt: no grant is issued and no state change occurs.
- rst asserted mid-transaction: the in-flight transaction is dropped, outputs clear immediately, and no rvalid is issued. The memory must tolerate mem_req dropping.
- No timeout: a missing mem_ack stalls the FSM indefinitely.

## Structure
- mem_arb_pkg holds:
  - arb_state_e (IDLE, BUSY_I, BUSY_D)
  - owner_e (OWN_I, OWN_D)
  - default ADDR_W, DATA_W and MAX_WAIT localparams
- Single module; no sub-module is warranted. The FSM, starve counter and request latch are compact enough to share one file.

## Test plan
- Fetch only, if_addr=0x0, memory returns 0x003100B3 with ack after 1 cycle → if_gnt at t, mem_req at t+1, if_rvalid at t+2 with if_rdata=0x003100B3.
- Simultaneous if_req (addr 0x4) and d_req read (addr 0x4, memory word 0xDEADBEEF) → d_gnt first, d_rdata=0xDEADBEEF; if_gnt in the IDLE cycle after, if_rvalid then returns the same word.
- Data write, d_addr=0x7, d_be=4'b0011, d_wdata=0x1234 → mem_addr=0x4, mem_be=0011, mem_we=1; d_rvalid pulses once.
- if_req held continuously while d_req is held continuously, MAX_WAIT=4 → 4 d_gnts, then 1 if_gnt, then data resumes.
- Memory ack delayed 5 cycles → mem_* outputs stable for all 6 cycles; a second requester stays ungranted until IDLE.
- rst low during BUSY_D → all outputs 0 at once; no d_rvalid after release; the next request proceeds normally from IDLE.
